overdrive_clipper: RTL and testbench
====================================

// Module: overdrive_clipper
// PURPOSE
//  Parametrised stereo-agnostic clipping stage for the multi-effects chain; successor to the single-mode threshold gate.
//  Signed two's-complement samples; symmetric hard or soft clipping about an encoder-adjustable threshold.
//  Fixed 2-cycle valid-qualified pipeline; saturating clip-event counter for the UI.
//  Sits between the ADC sample register and the effect mixer.
// PARAMETERS
//  DATA_W      12    sample width, signed two's complement
//  THR_DEFAULT 800   threshold after reset (magnitude, LSBs)
//  THR_STEP    100   threshold change per encoder event
//  THR_MIN     100   lowest threshold
//  THR_MAX     1500  highest threshold; must be < 2**(DATA_W-1)
//  CNT_W       16    clip counter width
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  rlrot      in   2       encoder: [1] event strobe (level), [0] direction (1 = up, 0 = down)
//  mode       in   2       00 bypass, 01 hard clip, 10 soft clip, 11 treated as bypass
//  in_valid   in   1       DATA_IN qualifier, one sample per pulse
//  DATA_IN    in   DATA_W  signed input sample
//  cnt_clr    in   1       synchronous clear of clip_cnt
//  out_valid  out  1       DATA_OUT qualifier
//  DATA_OUT   out  DATA_W  signed output sample
//  clip_flag  out  1       high with out_valid when that sample was clipped
//  threshold  out  DATA_W  current threshold (unsigned magnitude)
//  clip_cnt   out  CNT_W   saturating count of clipped samples
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   out_valid = 0, DATA_OUT = 0, clip_flag = 0, clip_cnt = 0, threshold = THR_DEFAULT, encoder history = 0.
//  Threshold control:
//   - One step per 0->1 edge of rlrot[1], sampled with a registered copy; holding rlrot[1] high is one event.
//   - Up: thr = min(thr + THR_STEP, THR_MAX). Down: thr = max(thr - THR_STEP, THR_MIN). Saturate, never wrap.
//   - New value is visible on threshold the cycle after the detected edge.
//  Pipeline (no backpressure; in_valid may be high every cycle):
//   - S1: on in_valid, register DATA_IN, mode, and threshold (snapshot); v1 <= in_valid.
//   - S2: compute from S1 values; out_valid <= v1; DATA_OUT and clip_flag update only when v1 = 1, else hold.
//   - Latency exactly 2 cycles from in_valid to out_valid.
//   - A threshold or mode change never alters a sample already in S1.
//  Arithmetic (x = S1 sample, t = snapshot threshold, using DATA_W+1 bit signed intermediates):
//   - Bypass: y = x, clip = 0.
//   - Hard: x > t -> y = t; x < -t -> y = -t; else y = x. clip = (|x| > t).
//   - Soft: x > t -> y = t + ((x - t) >>> 1); x < -t -> y = -t - ((-t - x) >> 1); else y = x. clip = (|x| > t).
//   - Most-negative input (-2**(DATA_W-1)) must be handled without overflow.
//   - Result always fits in DATA_W bits; no further saturation is required.
//   - |x| == t is not clipped.
//  Counter:
//   - clip_cnt += 1 on each S2 output with clip = 1; holds at all-ones.
//   - cnt_clr has priority over an increment in the same cycle; the result is 0.
//  Reset mid-stream: in-flight samples are discarded; out_valid is low until 2 cycles after the next in_valid.
// TESTING
//  1. Reset, then read threshold -> 800; clip_cnt = 0; out_valid = 0.
//  2. Mode 01, t = 800, inputs 500, 900, -900, 800 -> outputs 500, 800, -800, 800; clip_flag 0, 1, 1, 0; clip_cnt = 2.
//  3. Mode 10, t = 800, inputs 1000, -1000, 2047, -2048 -> outputs 900, -900, 1423, -1424.
//  4. 10 up events -> threshold 1500 (saturated). Hold rlrot[1] high 20 cycles -> one step only.
//     18 down events -> threshold 100.
//  5. Back-to-back in_valid with an encoder event between samples -> the earlier sample uses the old t,
//     the later sample uses the new t; out_valid asserts exactly 2 cycles after each in_valid.
//  6. Force clip_cnt to all-ones and clip again -> count holds. cnt_clr together with a clip -> 0.
//     Assert rst_n mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/overdrive_clipper.sv
// Symmetric hard/soft clipping stage with an encoder-driven threshold,
// a fixed two-stage valid-qualified pipeline and a saturating clip counter.
module overdrive_clipper #(
  parameter int DATA_W      = 12,
  parameter int THR_DEFAULT = 800,
  parameter int THR_STEP    = 100,
  parameter int THR_MIN     = 100,
  parameter int THR_MAX     = 1500,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               rlrot,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] DATA_IN,
  input  logic                     cnt_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] DATA_OUT,
  output logic                     clip_flag,
  output logic [DATA_W-1:0]        threshold,
  output logic [CNT_W-1:0]         clip_cnt
);

  localparam logic [DATA_W:0]   STEP_E  = (DATA_W+1)'(THR_STEP);
  localparam logic [DATA_W:0]   MIN_E   = (DATA_W+1)'(THR_MIN);
  localparam logic [DATA_W:0]   MAX_E   = (DATA_W+1)'(THR_MAX);
  localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THR_DEFAULT);

  // ---------------- threshold control ----------------
  logic              enc_q;
  logic              enc_edge;
  logic [DATA_W:0]   thr_e;
  logic [DATA_W:0]   thr_up;
  logic [DATA_W:0]   thr_dn;
  logic [DATA_W-1:0] thr_next;

  assign enc_edge = rlrot[1] & ~enc_q;

  // One bit of headroom so the step never wraps before saturation.
  always_comb begin
    thr_e  = {1'b0, threshold};
    thr_up = thr_e + STEP_E;
    thr_dn = thr_e - STEP_E;
    if (thr_up > MAX_E) thr_up = MAX_E;
    if (thr_e < (MIN_E + STEP_E)) thr_dn = MIN_E;
    thr_next = rlrot[0] ? thr_up[DATA_W-1:0] : thr_dn[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q     <= 1'b0;
      threshold <= THR_RST;
    end else begin
      enc_q <= rlrot[1];
      if (enc_edge) threshold <= thr_next;
    end
  end

  // Valid semantics: a sample transfers on every cycle in_valid is high; there
  // is no ready, and out_valid pulses exactly two cycles later for that sample.

  // ---------------- stage 1: capture ----------------
  logic                     v1;
  logic signed [DATA_W-1:0] x1;
  logic [1:0]               m1;
  logic [DATA_W-1:0]        t1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      m1 <= 2'b00;
      t1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        x1 <= DATA_IN;
        m1 <= mode;
        t1 <= threshold;
      end
    end
  end

  // ---------------- stage 2: clip arithmetic ----------------
  logic signed [DATA_W:0] xe;
  logic signed [DATA_W:0] te;
  logic signed [DATA_W:0] nte;
  logic signed [DATA_W:0] soft_pos;
  logic signed [DATA_W:0] soft_neg;
  logic signed [DATA_W:0] y_e;
  logic                   over_pos;
  logic                   over_neg;
  logic                   clip;

  // Extended width keeps -2**(DATA_W-1) and -t representable.
  always_comb begin
    xe       = {x1[DATA_W-1], x1};
    te       = {1'b0, t1};
    nte      = -te;
    over_pos = (xe > te);
    over_neg = (xe < nte);
    soft_pos = te + ((xe - te) >>> 1);
    soft_neg = nte - ((nte - xe) >>> 1);
    y_e      = xe;
    clip     = 1'b0;
    case (m1)
      2'b01: begin
        clip = over_pos | over_neg;
        if (over_pos)      y_e = te;
        else if (over_neg) y_e = nte;
      end
      2'b10: begin
        clip = over_pos | over_neg;
        if (over_pos)      y_e = soft_pos;
        else if (over_neg) y_e = soft_neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DATA_OUT  <= '0;
      clip_flag <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        DATA_OUT  <= y_e[DATA_W-1:0];
        clip_flag <= clip;
      end
    end
  end

  // ---------------- clip counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (cnt_clr) begin
      clip_cnt <= '0;
    end else if (v1 && clip && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_overdrive_clipper.sv
// Bench for overdrive_clipper: queue-based reference model checked every cycle,
// directed literal checks, then randomized traffic with encoder and resets.
module tb_overdrive_clipper;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int CNT_WS = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]               rlrot = 2'b00;
  logic [1:0]               mode = 2'b00;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] data_in = '0;
  logic                     cnt_clr = 1'b0;

  logic                     out_valid, out_valid_s;
  logic signed [DATA_W-1:0] data_out, data_out_s;
  logic                     clip_flag, clip_flag_s;
  logic [DATA_W-1:0]        threshold, threshold_s;
  logic [CNT_W-1:0]         clip_cnt;
  logic [CNT_WS-1:0]        clip_cnt_s;

  overdrive_clipper #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rlrot(rlrot), .mode(mode), .in_valid(in_valid),
    .DATA_IN(data_in), .cnt_clr(cnt_clr), .out_valid(out_valid), .DATA_OUT(data_out),
    .clip_flag(clip_flag), .threshold(threshold), .clip_cnt(clip_cnt)
  );

  // Narrow-counter copy on the same inputs exercises counter saturation.
  overdrive_clipper #(.DATA_W(DATA_W), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .rlrot(rlrot), .mode(mode), .in_valid(in_valid),
    .DATA_IN(data_in), .cnt_clr(cnt_clr), .out_valid(out_valid_s), .DATA_OUT(data_out_s),
    .clip_flag(clip_flag_s), .threshold(threshold_s), .clip_cnt(clip_cnt_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_clip(input int x, input int t, input int m,
                                   output int y, output bit c);
    c = (m == 1 || m == 2) && (x > t || x < -t);
    if (!c)          y = x;
    else if (m == 1) y = (x > t) ? t : -t;
    else             y = (x > t) ? t + (x - t) / 2 : -t - (-t - x) / 2;
  endfunction

  typedef struct { int due; int y; bit clip; } exp_t;
  exp_t pend[$];
  int   cyc = 0;
  int   thr_m = 800;
  bit   prev_m = 1'b0;
  bit   ov_m = 1'b0;
  int   y_m = 0;
  bit   clip_m = 1'b0;
  int   cnt_m = 0;
  int   cnt_s = 0;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      pend.delete();
      cyc = 0; thr_m = 800; prev_m = 1'b0; ov_m = 1'b0;
      y_m = 0; clip_m = 1'b0; cnt_m = 0; cnt_s = 0;
    end else begin
      cyc++;
      ov_m = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        ov_m = 1'b1; y_m = e.y; clip_m = e.clip;
      end
      if (cnt_clr) begin
        cnt_m = 0; cnt_s = 0;
      end else if (ov_m && clip_m) begin
        if (cnt_m < (1 << CNT_W) - 1)  cnt_m++;
        if (cnt_s < (1 << CNT_WS) - 1) cnt_s++;
      end
      if (in_valid) begin
        e.due = cyc + 1;
        ref_clip(int'(data_in), thr_m, int'(mode), e.y, e.clip);
        pend.push_back(e);
      end
      if (rlrot[1] && !prev_m)
        thr_m = rlrot[0] ? ((thr_m + 100 > 1500) ? 1500 : thr_m + 100)
                         : ((thr_m - 100 < 100) ? 100 : thr_m - 100);
      prev_m = rlrot[1];
    end
  end

  // ---------------- scoreboard compare ----------------
  int got_y[$];
  int got_c[$];

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(ov_m));
    chk("data_out", int'(data_out), y_m);
    chk("clip_flag", int'(clip_flag), int'(clip_m));
    chk("threshold", int'(threshold), thr_m);
    chk("clip_cnt", int'(clip_cnt), cnt_m);
    chk("clip_cnt_narrow", int'(clip_cnt_s), cnt_s);
    if (out_valid) begin
      got_y.push_back(int'(data_out));
      got_c.push_back(int'(clip_flag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enc_event(input bit dir);
    rlrot = {1'b1, dir}; tick();
    rlrot = {1'b0, dir}; tick();
  endtask

  task automatic run_samples(input int xs[4], input logic [1:0] m);
    got_y.delete(); got_c.delete();
    mode = m;
    foreach (xs[i]) begin
      in_valid = 1'b1; data_in = DATA_W'(xs[i]); tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  int hard_in[4]  = '{500, 900, -900, 800};
  int hard_out[4] = '{500, 800, -800, 800};
  int hard_clp[4] = '{0, 1, 1, 0};
  int soft_in[4]  = '{1000, -1000, 2047, -2048};
  int soft_out[4] = '{900, -900, 1423, -1424};

  initial begin
    int y; bit c; int r;

    // model pins
    ref_clip(1000, 800, 2, y, c);  chk("model_soft_pos", y, 900);
    ref_clip(-2048, 800, 2, y, c); chk("model_soft_min", y, -1424);
    ref_clip(800, 800, 1, y, c);   chk("model_edge_noclip", int'(c), 0);
    ref_clip(2047, 100, 2, y, c);  chk("model_soft_lowthr", y, 1073);

    // reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_threshold", int'(threshold), 800);
    chk("rst_clip_cnt", int'(clip_cnt), 0);
    chk("rst_out_valid", int'(out_valid), 0);

    // hard clip
    run_samples(hard_in, 2'b01);
    chk("hard_count", got_y.size(), 4);
    if (got_y.size() == 4)
      foreach (hard_in[i]) begin
        chk($sformatf("hard_y%0d", i), got_y[i], hard_out[i]);
        chk($sformatf("hard_c%0d", i), got_c[i], hard_clp[i]);
      end
    chk("hard_clip_cnt", int'(clip_cnt), 2);

    // soft clip
    run_samples(soft_in, 2'b10);
    chk("soft_count", got_y.size(), 4);
    if (got_y.size() == 4)
      foreach (soft_in[i]) chk($sformatf("soft_y%0d", i), got_y[i], soft_out[i]);

    // threshold snapshot across an encoder event between back-to-back samples
    got_y.delete(); got_c.delete();
    mode = 2'b01;
    in_valid = 1'b1; data_in = 12'sd1000; rlrot = 2'b11; tick();
    in_valid = 1'b1; data_in = 12'sd1000; rlrot = 2'b01; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("snap_count", got_y.size(), 2);
    if (got_y.size() == 2) begin
      chk("snap_old_t", got_y[0], 800);
      chk("snap_new_t", got_y[1], 900);
    end

    // counter clear wins over a same-cycle clip
    in_valid = 1'b1; data_in = 12'sd2000; tick();
    in_valid = 1'b0; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    chk("clr_priority_cnt", int'(clip_cnt), 0);
    chk("clr_priority_flag", int'(clip_flag), 1);

    // narrow counter saturates
    repeat (10) begin
      in_valid = 1'b1; data_in = -12'sd2000; tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_wide_cnt", int'(clip_cnt), 10);
    chk("sat_narrow_cnt", int'(clip_cnt_s), 7);

    // threshold limits and level-held strobe
    repeat (10) enc_event(1'b1);
    chk("thr_max", int'(threshold), 1500);
    rlrot = 2'b10; repeat (20) tick();
    rlrot = 2'b00; tick();
    chk("thr_hold_one_step", int'(threshold), 1400);
    repeat (18) enc_event(1'b0);
    chk("thr_min", int'(threshold), 100);

    // mid-stream reset
    mode = 2'b10;
    repeat (3) begin
      in_valid = 1'b1; data_in = 12'sd1900; tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_data_out", int'(data_out), 0);
    chk("mid_rst_clip_flag", int'(clip_flag), 0);
    chk("mid_rst_clip_cnt", int'(clip_cnt), 0);
    chk("mid_rst_threshold", int'(threshold), 800);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r == 0)      data_in = -12'sd2048;
      else if (r == 1) data_in = 12'sd2047;
      else             data_in = DATA_W'($urandom_range(0, 4095));
      mode    = 2'($urandom_range(0, 3));
      rlrot   = {($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
      cnt_clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; rlrot = 2'b00; cnt_clr = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
